serial_compare_scheduler: RTL and testbench
===========================================

# serial_compare_scheduler

Round-robin scheduler that shares a single bit-serial, MSB-first magnitude comparator among several requesters. Requesters each present an operand pair under a valid/ready handshake. The block grants one requester at a time and runs the serial comparison with early termination on the first differing bit. It then returns a less/equal/greater result tagged with the requester ID under a second valid/ready handshake. It sits between operand-producing units and the comparator datapath, and serializes all access to it.

## Interface

- WIDTH, 4, operand width in bits (≥2)
- NREQ, 4, number of requesters (2..8)
- IDW, derived, ID width = max(1, ceil(log2 NREQ))

- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- req_valid  in  NREQ  per-requester operand pair valid
- req_ready  out  NREQ  one-hot grant/accept; combinational
- req_a  in  NREQ*WIDTH  operand A, requester i at bits [i*WIDTH +: WIDTH]
- req_b  in  NREQ*WIDTH  operand B, same packing
- rsp_valid  out  1  result valid
- rsp_ready  in  1  result consumer ready
- rsp_id  out  IDW  requester index of the result
- rsp_lt, rsp_eq, rsp_gt  out  1 each  A<B, A==B, A>B (exactly one high while rsp_valid)
- busy  out  1  high whenever state ≠ IDLE

## Operation

- FSM states: IDLE, COMPARE, DONE.
- IDLE:
  - Pick winner g = first i with req_valid[i], searching from ptr+1 upward modulo NREQ.
  - Drive req_ready[g]=1; all other bits 0.
  - If no req_valid bit is high, req_ready = 0.
  - On accept (req_valid[g] & req_ready[g] at the edge): sh_a←req_a[g], sh_b←req_b[g], id←g, ptr←g, cnt←WIDTH, go to COMPARE.
- COMPARE, one bit per cycle, examining sh_a[WIDTH-1] and sh_b[WIDTH-1]:
  - Bits differ: rsp_gt=sh_a MSB, rsp_lt=sh_b MSB, rsp_eq=0; go to DONE.
  - Bits equal and cnt==1: rsp_eq=1, rsp_lt=rsp_gt=0; go to DONE.
  - Otherwise: shift sh_a and sh_b left by 1, cnt←cnt−1, stay in COMPARE.
  - req_ready = 0 in this state.
- DONE:
  - rsp_valid=1; rsp_id, rsp_lt, rsp_eq and rsp_gt are held stable.
  - On rsp_valid & rsp_ready: go to IDLE.
  - req_ready = 0.
- Requester rules:
  - A requester must hold req_a/req_b stable while its req_valid is high and not yet accepted.
  - Dropping req_valid before acceptance is legal; that requester is simply skipped.
- Fairness: a requester that holds req_valid high is granted within NREQ grants.
- Unsigned comparison only.

## Timing

- Reset values:
  - State IDLE, ptr=NREQ−1 (requester 0 has first priority).
  - cnt=0, sh_a=sh_b=0, rsp_id=0.
  - rsp_lt=rsp_eq=rsp_gt=0, rsp_valid=0, busy=0.
  - req_ready follows IDLE arbitration in the first cycle after reset.
- Latency:
  - Let k = 1-based position of the first differing bit counted from the MSB, or k=WIDTH if A==B.
  - rsp_valid rises k cycles after the accept edge.
  - The decision is registered at the k-th edge after accept.
- Throughput with rsp_ready tied high: one comparison every k+2 cycles (accept, k compare cycles, DONE cycle). The next accept happens in the IDLE cycle that follows.
- Result flags change only on the COMPARE→DONE edge. They stay stable until the following accept.
- Backpressure: DONE persists indefinitely while rsp_ready=0. No new grant is issued in that time.
- Reset is asserted mid-COMPARE or in DONE: the transaction is aborted and no response is produced. All outputs take their reset values at the next edge. The ptr resets too.
- Requesters whose req_valid is high during reset are not accepted on the reset edge.
- Simultaneous events: rsp handshake and new req_valid in the same cycle → the new accept happens in the following IDLE cycle only.

## Test plan

- WIDTH=4; only req 0 presents A=0xA, B=0x9 → rsp_valid 3 cycles after accept; rsp_gt=1, rsp_id=0.
- Only req 2 presents A=0x3, B=0xB → rsp_valid 1 cycle after accept; rsp_lt=1, rsp_id=2. Only req 1 presents A=B=0x5 → rsp_valid 4 cycles after accept; rsp_eq=1, rsp_id=1.
- All four req_valid held high, rsp_ready=1, distinct operands → grant order 0,1,2,3,0; req_ready is one-hot and appears only in IDLE cycles.
- Hold rsp_ready=0 for 5 cycles in DONE → rsp_valid, rsp_id and flags stay stable, busy=1, req_ready=0. Release rsp_ready → IDLE on the next edge, then the next grant.
- Assert reset for 1 cycle at the 2nd COMPARE cycle of A=0x8, B=0x8 → no rsp_valid. Outputs show reset values, and the next grant goes to requester 0.
- Requester 1 valid, then requester 1 drops valid while requester 0 is being serviced → requester 1 is never granted and no spurious response appears.

Source files
------------

// File: rtl/serial_compare_scheduler.sv
// Round-robin arbiter in front of one shared bit-serial, MSB-first unsigned comparator.
// Requesters hand over an operand pair; the result returns with the winner's ID.
module serial_compare_scheduler #(
  parameter int WIDTH = 4,
  parameter int NREQ  = 4,
  localparam int IDW  = (NREQ > 2) ? $clog2(NREQ) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic                  rsp_lt,
  output logic                  rsp_eq,
  output logic                  rsp_gt,
  output logic                  busy
);

  localparam int CNTW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, COMPARE, DONE} state_e;

  state_e           state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] sh_a_q, sh_a_d;
  logic [WIDTH-1:0] sh_b_q, sh_b_d;
  logic             lt_q, lt_d;
  logic             eq_q, eq_d;
  logic             gt_q, gt_d;

  logic [WIDTH-1:0] a_arr [NREQ];
  logic [WIDTH-1:0] b_arr [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign a_arr[i] = req_a[i*WIDTH +: WIDTH];
    assign b_arr[i] = req_b[i*WIDTH +: WIDTH];
  end

  // Rotating search starting just after the last winner gives round-robin fairness.
  logic           found;
  logic [IDW-1:0] gnt_idx;
  logic [IDW-1:0] cand;

  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int off = 1; off <= NREQ; off++) begin
      cand = IDW'((int'(ptr_q) + off) % NREQ);
      if (!found && req_valid[cand]) begin
        found   = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  logic accept;
  assign accept    = (state_q == IDLE) && found;
  assign req_ready = accept ? (NREQ'(1) << gnt_idx) : '0;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    cnt_d   = cnt_q;
    sh_a_d  = sh_a_q;
    sh_b_d  = sh_b_q;
    lt_d    = lt_q;
    eq_d    = eq_q;
    gt_d    = gt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          sh_a_d  = a_arr[gnt_idx];
          sh_b_d  = b_arr[gnt_idx];
          id_d    = gnt_idx;
          ptr_d   = gnt_idx;
          cnt_d   = CNTW'(WIDTH);
          state_d = COMPARE;
        end
      end
      COMPARE: begin
        // First differing bit from the MSB decides; equal operands run all WIDTH bits.
        if (sh_a_q[WIDTH-1] != sh_b_q[WIDTH-1]) begin
          gt_d    = sh_a_q[WIDTH-1];
          lt_d    = sh_b_q[WIDTH-1];
          eq_d    = 1'b0;
          state_d = DONE;
        end else if (cnt_q == CNTW'(1)) begin
          gt_d    = 1'b0;
          lt_d    = 1'b0;
          eq_d    = 1'b1;
          state_d = DONE;
        end else begin
          sh_a_d = {sh_a_q[WIDTH-2:0], 1'b0};
          sh_b_d = {sh_b_q[WIDTH-2:0], 1'b0};
          cnt_d  = cnt_q - CNTW'(1);
        end
      end
      DONE: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= IDW'(NREQ - 1);
      id_q    <= '0;
      cnt_q   <= '0;
      sh_a_q  <= '0;
      sh_b_q  <= '0;
      lt_q    <= 1'b0;
      eq_q    <= 1'b0;
      gt_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
      sh_a_q  <= sh_a_d;
      sh_b_q  <= sh_b_d;
      lt_q    <= lt_d;
      eq_q    <= eq_d;
      gt_q    <= gt_d;
    end
  end

  assign rsp_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign rsp_id    = id_q;
  assign rsp_lt    = lt_q;
  assign rsp_eq    = eq_q;
  assign rsp_gt    = gt_q;

endmodule

// File: tb/tb_serial_compare_scheduler.sv
// Bench for serial_compare_scheduler: abstract per-cycle reference model plus
// directed scenarios with hand-computed latencies, grant orders and results.
module tb_serial_compare_scheduler;
  localparam int WIDTH = 4;
  localparam int NREQ  = 4;
  localparam int IDW   = 2;

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic [NREQ-1:0]       req_valid = '0;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a = '0;
  logic [NREQ*WIDTH-1:0] req_b = '0;
  logic                  rsp_valid;
  logic                  rsp_ready = 1'b1;
  logic [IDW-1:0]        rsp_id;
  logic                  rsp_lt, rsp_eq, rsp_gt, busy;

  serial_compare_scheduler #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_lt(rsp_lt), .rsp_eq(rsp_eq), .rsp_gt(rsp_gt), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: phase 0 idle, 1 comparing (m_left cycles to go), 2 result pending.
  bit              m_init = 1'b0;
  int              m_phase, m_left, m_ptr, m_id, m_w, m_k;
  bit              m_lt, m_eq, m_gt, p_lt, p_eq, p_gt;
  logic [WIDTH-1:0] m_a, m_b, m_x;
  logic [NREQ-1:0] m_rdy;
  int              n_rsp = 0;
  bit              saw_g1 = 1'b0;

  function automatic int winner(input int ptr, input logic [NREQ-1:0] v);
    for (int off = 1; off <= NREQ; off++)
      if (v[(ptr + off) % NREQ]) return (ptr + off) % NREQ;
    return -1;
  endfunction

  always @(negedge clk) begin
    if (m_init) begin
      m_w   = winner(m_ptr, req_valid);
      m_rdy = (m_phase == 0 && m_w >= 0) ? (NREQ'(1) << m_w) : '0;
      chk("req_ready", 32'(req_ready), 32'(m_rdy));
      chk("rsp_valid", 32'(rsp_valid), 32'(m_phase == 2));
      chk("busy", 32'(busy), 32'(m_phase != 0));
      chk("rsp_id", 32'(rsp_id), 32'(m_id));
      chk("flags", 32'({rsp_lt, rsp_eq, rsp_gt}), 32'({m_lt, m_eq, m_gt}));
      if (req_ready[1]) saw_g1 = 1'b1;
      if (rsp_valid && rsp_ready) n_rsp++;
    end
    if (reset) begin
      m_init = 1'b1; m_phase = 0; m_ptr = NREQ - 1; m_id = 0;
      m_lt = 1'b0; m_eq = 1'b0; m_gt = 1'b0;
    end else if (m_init) begin
      case (m_phase)
        0: begin
          m_w = winner(m_ptr, req_valid);
          if (m_w >= 0) begin
            m_a = req_a[m_w*WIDTH +: WIDTH];
            m_b = req_b[m_w*WIDTH +: WIDTH];
            m_x = m_a ^ m_b;
            m_k = WIDTH;
            for (int i = 0; i < WIDTH; i++) if (m_x[i]) m_k = WIDTH - i;
            p_lt = (m_a < m_b); p_eq = (m_a == m_b); p_gt = (m_a > m_b);
            m_id = m_w; m_ptr = m_w; m_left = m_k; m_phase = 1;
          end
        end
        1: begin
          m_left--;
          if (m_left == 0) begin
            m_phase = 2; m_lt = p_lt; m_eq = p_eq; m_gt = p_gt;
          end
        end
        default: if (rsp_ready) m_phase = 0;
      endcase
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic set_req(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    req_a[i*WIDTH +: WIDTH] = a;
    req_b[i*WIDTH +: WIDTH] = b;
  endtask

  task automatic wait_grant(input int i, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (req_ready[i]) begin ok = 1'b1; break; end
    end
  endtask

  task automatic drain();
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (!busy) break;
    end
    step();
  endtask

  task automatic run_one(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input int exp_lat, input logic [2:0] exp_flags);
    bit ok;
    int lat;
    set_req(i, a, b);
    req_valid[i] = 1'b1;
    wait_grant(i, ok);
    chk("grant_seen", 32'(ok), 32'(1));
    step();
    req_valid[i] = 1'b0;
    lat = 0;
    do begin
      @(posedge clk); lat++; @(negedge clk);
    end while (!rsp_valid && lat < 20);
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("result_flags", 32'({rsp_lt, rsp_eq, rsp_gt}), 32'(exp_flags));
    chk("result_id", 32'(rsp_id), 32'(i));
    step();
  endtask

  int exp_order [5] = '{0, 1, 2, 3, 0};
  int got;
  bit ok;
  int n0;
  logic [5:0] held;

  initial begin
    step(); step();
    reset = 1'b0;
    @(negedge clk);
    chk("reset_busy", 32'(busy), 32'(0));
    chk("reset_rsp_valid", 32'(rsp_valid), 32'(0));
    chk("reset_id_flags", 32'({rsp_id, rsp_lt, rsp_eq, rsp_gt}), 32'(0));
    step();

    // Single requesters: early termination at bit 3, bit 1, and full-length equality.
    run_one(0, 4'hA, 4'h9, 3, 3'b001);
    run_one(2, 4'h3, 4'hB, 1, 3'b100);
    run_one(1, 4'h5, 4'h5, 4, 3'b010);

    // All requesters contending from a fresh reset: strict rotation.
    reset = 1'b1; step(); reset = 1'b0;
    set_req(0, 4'h1, 4'h2); set_req(1, 4'h7, 4'h3);
    set_req(2, 4'hC, 4'hC); set_req(3, 4'h0, 4'hF);
    req_valid = 4'hF;
    for (int g = 0; g < 5; g++) begin
      got = -1;
      for (int n = 0; n < 40 && got < 0; n++) begin
        @(negedge clk);
        for (int j = 0; j < NREQ; j++) if (req_ready[j]) got = j;
      end
      chk("grant_order", 32'(got), 32'(exp_order[g]));
      step();
    end
    req_valid = '0;
    drain();

    // Backpressure: result held while rsp_ready is low, req 0 waits.
    rsp_ready = 1'b0;
    set_req(3, 4'h1, 4'h2); set_req(0, 4'h4, 4'h4);
    req_valid = 4'b1001;
    wait_grant(3, ok);
    chk("bp_grant3", 32'(ok), 32'(1));
    step();
    req_valid[3] = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (rsp_valid) break;
    end
    held = {rsp_valid, rsp_id, rsp_lt, rsp_eq, rsp_gt};
    chk("bp_first", 32'(held), 32'({1'b1, 2'd3, 3'b100}));
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_hold", 32'({rsp_valid, rsp_id, rsp_lt, rsp_eq, rsp_gt}), 32'(held));
      chk("bp_busy_noready", 32'({busy, req_ready}), 32'({1'b1, 4'b0000}));
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    step();
    @(negedge clk);
    chk("bp_release_grant0", 32'({busy, req_ready}), 32'({1'b0, 4'b0001}));
    step();
    req_valid = '0;
    drain();

    // Reset during the second compare cycle aborts the transaction.
    set_req(0, 4'h8, 4'h8);
    req_valid = 4'b0001;
    wait_grant(0, ok);
    chk("abort_grant0", 32'(ok), 32'(1));
    step();
    req_valid = '0;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    n0 = n_rsp;
    @(negedge clk);
    chk("abort_outputs", 32'({rsp_valid, busy, rsp_id, rsp_lt, rsp_eq, rsp_gt}), 32'(0));
    for (int c = 0; c < 6; c++) @(negedge clk);
    chk("abort_no_rsp", 32'(n_rsp - n0), 32'(0));

    // Requester 1 withdraws while requester 0 is serviced.
    step();
    saw_g1 = 1'b0;
    set_req(0, 4'h6, 4'h5); set_req(1, 4'h7, 4'h7);
    req_valid = 4'b0011;
    @(negedge clk);
    chk("after_reset_grant0", 32'(req_ready), 32'(4'b0001));
    n0 = n_rsp;
    step();
    req_valid = '0;
    for (int c = 0; c < 15; c++) @(negedge clk);
    chk("withdraw_one_rsp", 32'(n_rsp - n0), 32'(1));
    chk("withdraw_no_g1", 32'(saw_g1), 32'(0));
    chk("withdraw_last_gt", 32'({rsp_id, rsp_lt, rsp_eq, rsp_gt}), 32'({2'd0, 3'b001}));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
